// File: rtl/zfp_pkg.sv
// Shared ZFP decode types and widths.
// Used by inv_cast and the inverse block-transform path.
package zfp_pkg;

  localparam int FP_W      = 64;
  localparam int EXP_W     = 11;
  localparam int FRAC_W    = 52;
  localparam int INT_W     = 64;
  localparam int EXP_BIAS  = 1023;
  localparam int BLOCK_LEN = 4;
  localparam int CNT_W     = $clog2(BLOCK_LEN);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  typedef logic [EXP_W-1:0] ex_t;
  typedef logic signed [INT_W-1:0] int_t;

endpackage

// File: rtl/inv_cast_norm.sv
// Block-floating-point integer to IEEE double: sign/abs, LZC,
// fraction align, exponent compute with flush-to-zero and saturation.
import zfp_pkg::*;

module inv_cast_norm (
  input  logic [INT_W-1:0] int_i,
  input  logic [EXP_W-1:0] ex_i,
  output logic [FP_W-1:0]  fp_o
);

  localparam logic signed [EXP_W+1:0] EB_OFF =
    (EXP_W+2)'(INT_W-2);
  localparam logic signed [EXP_W+1:0] EB_MAX =
    (EXP_W+2)'((1 << EXP_W) - 1);

  logic                     sgn;
  logic [INT_W-1:0]         mag;
  logic [INT_W-1:0]         mn;
  logic [5:0]               p;
  logic signed [EXP_W+1:0]  eb;
  fp_t                      res;
  logic                     unused_ok;

  always_comb begin
    sgn = int_i[INT_W-1];
    mag = sgn ? (~int_i + 1'b1) : int_i;
    p = '0;
    for (int k = 0; k < INT_W; k++) begin
      if (mag[k]) p = 6'(k);
    end
    mn = mag << (6'(INT_W-1) - p);
    eb = $signed({2'b00, ex_i})
       + $signed({7'b0, p}) - EB_OFF;
    res = '0;
    if (mag == '0) begin
      res = '0;
    end else if (eb[EXP_W+1] || eb == '0) begin
      res.sign = sgn;
    end else if (eb >= EB_MAX) begin
      res.sign = sgn;
      res.expo = '1;
    end else begin
      res.sign = sgn;
      res.expo = eb[EXP_W-1:0];
      // leading one drops out; low bits truncate
      res.frac = mn[INT_W-2 -: FRAC_W];
    end
  end

  assign fp_o = res;
  assign unused_ok = ^{mn[INT_W-1], mn[INT_W-FRAC_W-2:0]};

endmodule

// File: rtl/inv_cast.sv
// ZFP inverse cast: emax token + BLOCK_LEN ints -> doubles.
// INV_CAST_PIPE_EN adds a second stage (latency 2).
import zfp_pkg::*;

module inv_cast (
  input  logic             clk,
  input  logic             reset,
  input  logic [EXP_W-1:0] s_ex_data,
  input  logic             s_ex_valid,
  output logic             s_ex_ready,
  input  logic [INT_W-1:0] s_int_data,
  input  logic             s_int_valid,
  output logic             s_int_ready,
  output logic [FP_W-1:0]  m_fp_data,
  output logic             m_fp_valid,
  input  logic             m_fp_ready
);

  ex_t              ex_q, ex_d;
  logic             ex_v_q, ex_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0]  fp_q, fp_d;
  logic             ov_q, ov_d;

  logic             int_fire, ex_fire, last, rdy_in;
  logic [FP_W-1:0]  nfp;

`ifdef INV_CAST_PIPE_EN
  logic             v1_q, v1_d;
  logic [INT_W-1:0] i1_q, i1_d;
  ex_t              e1_q, e1_d;
  logic             rdy2;

  assign rdy2   = !ov_q || m_fp_ready;
  assign rdy_in = !v1_q || rdy2;

  inv_cast_norm u_norm (
    .int_i (i1_q),
    .ex_i  (e1_q),
    .fp_o  (nfp)
  );
`else
  assign rdy_in = !ov_q || m_fp_ready;

  inv_cast_norm u_norm (
    .int_i (s_int_data),
    .ex_i  (ex_q),
    .fp_o  (nfp)
  );
`endif

  assign last        = cnt_q == CNT_W'(BLOCK_LEN-1);
  assign s_int_ready = !reset && ex_v_q && rdy_in;
  assign int_fire    = s_int_valid && s_int_ready;
  // next emax may load alongside the block's last int
  assign s_ex_ready  = !reset && (!ex_v_q || (int_fire && last));
  assign ex_fire     = s_ex_valid && s_ex_ready;

  assign m_fp_data  = fp_q;
  assign m_fp_valid = ov_q;

  always_comb begin
    ex_d   = ex_q;
    ex_v_d = ex_v_q;
    cnt_d  = cnt_q;
    fp_d   = fp_q;
    ov_d   = ov_q;
    if (int_fire) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) ex_v_d = 1'b0;
    end
    if (ex_fire) begin
      ex_d   = s_ex_data;
      ex_v_d = 1'b1;
    end
`ifdef INV_CAST_PIPE_EN
    v1_d = v1_q;
    i1_d = i1_q;
    e1_d = e1_q;
    if (int_fire) begin
      v1_d = 1'b1;
      i1_d = s_int_data;
      e1_d = ex_q;
    end else if (rdy2) begin
      v1_d = 1'b0;
    end
    if (v1_q && rdy2) begin
      fp_d = nfp;
      ov_d = 1'b1;
    end else if (m_fp_ready) begin
      ov_d = 1'b0;
    end
`else
    if (int_fire) begin
      fp_d = nfp;
      ov_d = 1'b1;
    end else if (m_fp_ready) begin
      ov_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q   <= '0;
      ex_v_q <= 1'b0;
      cnt_q  <= '0;
      fp_q   <= '0;
      ov_q   <= 1'b0;
`ifdef INV_CAST_PIPE_EN
      v1_q   <= 1'b0;
      i1_q   <= '0;
      e1_q   <= '0;
`endif
    end else begin
      ex_q   <= ex_d;
      ex_v_q <= ex_v_d;
      cnt_q  <= cnt_d;
      fp_q   <= fp_d;
      ov_q   <= ov_d;
`ifdef INV_CAST_PIPE_EN
      v1_q   <= v1_d;
      i1_q   <= i1_d;
      e1_q   <= e1_d;
`endif
    end
  end

endmodule

// File: tb/tb_inv_cast.sv
// Randomized + directed bench for inv_cast against a value-level model.
// Build with INV_CAST_PIPE_EN to check the two-stage variant.
module tb_inv_cast;

`ifdef INV_CAST_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] s_ex_data;
  logic        s_ex_valid;
  logic        s_ex_ready;
  logic [63:0] s_int_data;
  logic        s_int_valid;
  logic        s_int_ready;
  logic [63:0] m_fp_data;
  logic        m_fp_valid;
  logic        m_fp_ready;

  always #5 clk = ~clk;

  inv_cast dut (
    .clk         (clk),
    .reset       (reset),
    .s_ex_data   (s_ex_data),
    .s_ex_valid  (s_ex_valid),
    .s_ex_ready  (s_ex_ready),
    .s_int_data  (s_int_data),
    .s_int_valid (s_int_valid),
    .s_int_ready (s_int_ready),
    .m_fp_data   (m_fp_data),
    .m_fp_valid  (m_fp_valid),
    .m_fp_ready  (m_fp_ready)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit lat_chk = 0;
  bit gaps = 0;
  int rdy_mode = 0;

  logic [63:0] exp_q[$];
  int          cq[$];
  int          out_cyc_q[$];
  logic [10:0] ex_src[$];
  logic [63:0] int_src[$];
  logic [63:0] hold_d;
  bit          hold_v = 0;

  // value = i * 2^(e - 1023 - 62), rounded toward zero into a double
  function automatic logic [63:0] model(logic [10:0] e, logic [63:0] i);
    logic        s;
    logic [63:0] m;
    logic [51:0] f;
    int          p;
    int          eb;
    s = i[63];
    m = s ? (64'd0 - i) : i;
    if (m == 64'd0) return 64'd0;
    p = $clog2(m + 64'd1) - 1;
    eb = int'(e) + p - 62;
    if (eb <= 0) return {s, 63'd0};
    if (eb >= 2047) return {s, 11'h7ff, 52'd0};
    if (p >= 52) f = 52'(m >> (p - 52));
    else f = 52'(m << (52 - p));
    return {s, 11'(eb), f};
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, expv);
    end
  endtask

  task automatic fail_now(string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_fp_ready = 1'b1;
      1:       m_fp_ready = 1'($urandom_range(0, 1));
      default: m_fp_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    int c;
    cyc++;
    if (reset || !mon_en) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 64'(m_fp_valid), 64'd1);
        check("hold_data", m_fp_data, hold_d);
      end
      if (m_fp_valid && m_fp_ready) begin
        if (exp_q.size() == 0) fail_now("spurious_output");
        else check("fp_out", m_fp_data, exp_q.pop_front());
        out_cyc_q.push_back(cyc);
        if (cq.size() > 0) begin
          c = cq.pop_front();
          if (lat_chk) check("latency", 64'(cyc - c), 64'(LAT));
        end
      end
      hold_v = m_fp_valid && !m_fp_ready;
      hold_d = m_fp_data;
      if (s_int_valid && s_int_ready) cq.push_back(cyc);
    end
  end

  task automatic add_block(logic [10:0] e, logic [63:0] a,
                           logic [63:0] b, logic [63:0] c,
                           logic [63:0] d);
    ex_src.push_back(e);
    int_src.push_back(a);
    int_src.push_back(b);
    int_src.push_back(c);
    int_src.push_back(d);
    exp_q.push_back(model(e, a));
    exp_q.push_back(model(e, b));
    exp_q.push_back(model(e, c));
    exp_q.push_back(model(e, d));
  endtask

  task automatic drive_ex();
    int n;
    while (ex_src.size() > 0) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_ex_data = ex_src.pop_front();
      s_ex_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_ex_ready && n < 2000);
      if (n >= 2000) begin
        fail_now("ex_timeout");
        ex_src.delete();
      end
      @(posedge clk);
      #1;
      s_ex_valid = 1'b0;
    end
  endtask

  task automatic drive_int();
    int n;
    while (int_src.size() > 0) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_int_data = int_src.pop_front();
      s_int_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_int_ready && n < 2000);
      if (n >= 2000) begin
        fail_now("int_timeout");
        int_src.delete();
      end
      @(posedge clk);
      #1;
      s_int_valid = 1'b0;
    end
  endtask

  task automatic run();
    fork
      drive_ex();
      drive_int();
    join
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd_int();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = {$urandom, $urandom};
      1:       v = 64'($urandom_range(0, 15));
      2:       v = 64'd1 << $urandom_range(0, 63);
      3:       v = 64'd0 - (64'd1 << $urandom_range(0, 62));
      4:       v = 64'h8000_0000_0000_0000;
      default: v = {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
    return v;
  endfunction

  function automatic logic [10:0] rnd_ex();
    case ($urandom_range(0, 2))
      0:       return 11'($urandom_range(0, 2047));
      1:       return 11'($urandom_range(0, 70));
      default: return 11'($urandom_range(1980, 2047));
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    s_ex_valid = 1'b0;
    s_ex_data = '0;
    s_int_valid = 1'b0;
    s_int_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(m_fp_valid), 64'd0);
    check("rst_data", m_fp_data, 64'd0);
    check("rst_ex_rdy", 64'(s_ex_ready), 64'd0);
    check("rst_int_rdy", 64'(s_int_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_ex_rdy", 64'(s_ex_ready), 64'd1);
    check("idle_int_rdy", 64'(s_int_ready), 64'd0);

    check("pin_one", model(11'h400, 64'h2000_0000_0000_0000),
          64'h3FF0_0000_0000_0000);
    check("pin_mone", model(11'h400, 64'hE000_0000_0000_0000),
          64'hBFF0_0000_0000_0000);
    check("pin_half", model(11'h400, 64'h1000_0000_0000_0000),
          64'h3FE0_0000_0000_0000);
    check("pin_zero", model(11'h400, 64'd0), 64'd0);
    check("pin_flush", model(11'h001, 64'd1), 64'd0);
    check("pin_big", model(11'h7FE, 64'h4000_0000_0000_0000),
          64'h7FE0_0000_0000_0000);
    check("pin_inf", model(11'h7FF, 64'h4000_0000_0000_0000),
          64'h7FF0_0000_0000_0000);
    check("pin_minint", model(11'h400, 64'h8000_0000_0000_0000),
          64'hC010_0000_0000_0000);
    check("pin_three", model(11'h400, 64'd3),
          64'h3C38_0000_0000_0000);

    mon_en = 1;
    @(posedge clk);
    #1;

    // directed block, ready held high
    lat_chk = 1;
    out_cyc_q.delete();
    add_block(11'h400, 64'h2000_0000_0000_0000,
              64'hE000_0000_0000_0000,
              64'h1000_0000_0000_0000, 64'd0);
    run();
    drain();
    check("t1_count", 64'(out_cyc_q.size()), 64'd4);
    if (out_cyc_q.size() == 4)
      check("t1_span", 64'(out_cyc_q[3] - out_cyc_q[0]), 64'd3);

    // flush, saturation and large-magnitude edges
    add_block(11'h001, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h4000_0000_0000_0000);
    add_block(11'h7FE, 64'h4000_0000_0000_0000,
              64'h8000_0000_0000_0000,
              64'h7FFF_FFFF_FFFF_FFFF, 64'd5);
    add_block(11'h7FF, 64'h4000_0000_0000_0000,
              64'hC000_0000_0000_0000, 64'd1, 64'd0);
    run();
    drain();

    // back-to-back blocks, no bubble
    out_cyc_q.delete();
    add_block(11'h400, 64'h2000_0000_0000_0000,
              64'hE000_0000_0000_0000,
              64'h1000_0000_0000_0000, 64'd0);
    add_block(11'h3F0, 64'd12345, 64'hFFFF_FFFF_0000_0000,
              64'h0123_4567_89AB_CDEF, 64'd7);
    run();
    drain();
    check("t3_count", 64'(out_cyc_q.size()), 64'd8);
    if (out_cyc_q.size() == 8)
      check("t3_span", 64'(out_cyc_q[7] - out_cyc_q[0]), 64'd7);

    // downstream stall mid-block
    lat_chk = 0;
    out_cyc_q.delete();
    add_block(11'h410, 64'd100, 64'd200, 64'd300, 64'd400);
    fork
      run();
      begin
        n = 0;
        while (out_cyc_q.size() < 2 && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (out_cyc_q.size() < 2) fail_now("t4_start_timeout");
        rdy_mode = 2;
        repeat (6) @(negedge clk);
        check("t4_stall_int_rdy", 64'(s_int_ready), 64'd0);
        check("t4_stall_valid", 64'(m_fp_valid), 64'd1);
        rdy_mode = 0;
      end
    join
    drain();
    check("t4_count", 64'(out_cyc_q.size()), 64'd4);

    // ints offered before any emax
    lat_chk = 1;
    add_block(11'h400, 64'h2000_0000_0000_0000,
              64'hE000_0000_0000_0000,
              64'h1000_0000_0000_0000, 64'd0);
    fork
      drive_int();
      begin
        repeat (3) begin
          @(negedge clk);
          check("t5_int_rdy", 64'(s_int_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        drive_ex();
      end
    join
    drain();

    // reset after two ints of a block
    ex_src.push_back(11'h400);
    int_src.push_back(64'h2000_0000_0000_0000);
    int_src.push_back(64'hE000_0000_0000_0000);
    exp_q.push_back(model(11'h400, 64'h2000_0000_0000_0000));
    exp_q.push_back(model(11'h400, 64'hE000_0000_0000_0000));
    run();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_valid", 64'(m_fp_valid), 64'd0);
    check("t6_ex_rdy", 64'(s_ex_ready), 64'd0);
    check("t6_int_rdy", 64'(s_int_ready), 64'd0);
    exp_q.delete();
    cq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_cyc_q.delete();
    add_block(11'h400, 64'h2000_0000_0000_0000,
              64'hE000_0000_0000_0000,
              64'h1000_0000_0000_0000, 64'd0);
    run();
    drain();
    check("t6_count", 64'(out_cyc_q.size()), 64'd4);

    // random traffic with random backpressure and gaps
    lat_chk = 0;
    rdy_mode = 1;
    gaps = 1;
    for (int b = 0; b < 40; b++)
      add_block(rnd_ex(), rnd_int(), rnd_int(), rnd_int(), rnd_int());
    run();
    drain();
    rdy_mode = 0;
    gaps = 0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
